// File: rtl/rx_credit_buffer_spw_pkg.sv
// spw_rx_pkg: shared SpaceWire receive-side constants and types.
package spw_rx_pkg;
  localparam int NCHAR_W = 9;
  localparam int FCT_CREDIT = 8;
  localparam int MAX_CREDIT_DEFAULT = 56;
  localparam int FLAG_BIT = 8;
  localparam logic [7:0] EOP = 8'h00;
  localparam logic [7:0] EEP = 8'h01;
  typedef logic [NCHAR_W-1:0] nchar_t;
endpackage

// File: rtl/rx_credit_buffer_spw_if.sv
// rx_credit_buffer_spw_if: receiver, consumer and FCT handshake signals of the receive buffer.
interface rx_credit_buffer_spw_if #(parameter int AW = 6);
  import spw_rx_pkg::*;
  logic link_enable;
  logic rx_got_null;
  logic rx_error;
  nchar_t rx_data_flag;
  logic rx_buffer_write;
  logic rd_en;
  nchar_t rd_data;
  logic rd_valid;
  logic [AW:0] fifo_count;
  logic fct_request;
  logic fct_ack;
  logic [5:0] credit_count;
  logic first_null;
  logic credit_error;
  modport master(
    output link_enable, rx_got_null, rx_error, rx_data_flag, rx_buffer_write, rd_en, fct_ack,
    input rd_data, rd_valid, fifo_count, fct_request, credit_count, first_null, credit_error
  );
  modport slave(
    input link_enable, rx_got_null, rx_error, rx_data_flag, rx_buffer_write, rd_en, fct_ack,
    output rd_data, rd_valid, fifo_count, fct_request, credit_count, first_null, credit_error
  );
endinterface

// File: rtl/rx_credit_buffer_spw_fifo.sv
// spw_fifo_sync: single-clock first-word fall-through FIFO of N-chars with occupancy count.
module spw_fifo_sync
  import spw_rx_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW = 6
) (
  input  logic        posedge_clk,
  input  logic        rx_resetn,
  input  logic        i_wr_en,
  input  logic        i_rd_en,
  input  nchar_t      i_wr_data,
  output nchar_t      o_rd_data,
  output logic        o_empty,
  output logic        o_full,
  output logic [AW:0] o_count
);
  nchar_t r_mem [DEPTH];
  nchar_t r_last;
  logic [AW:0] r_wptr, r_rptr;
  logic w_pop, w_push;
  assign o_count = r_wptr - r_rptr;
  assign o_empty = o_count == '0;
  assign o_full = o_count == (AW+1)'(DEPTH);
  assign w_pop = i_rd_en & ~o_empty;
  assign w_push = i_wr_en & (~o_full | w_pop);
  // When empty, show the last popped char rather than a stale memory slot.
  assign o_rd_data = o_empty ? r_last : r_mem[r_rptr[AW-1:0]];
  always_ff @(posedge posedge_clk)
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wr_data;
  always_ff @(posedge posedge_clk or negedge rx_resetn)
    if (!rx_resetn) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_last <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
        r_last <= r_mem[r_rptr[AW-1:0]];
      end
    end
endmodule

// File: rtl/rx_credit_buffer_spw.sv
// rx_credit_buffer_spw: receive N-char buffer with FCT credit tracking and credit-error detection.
module rx_credit_buffer_spw
  import spw_rx_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW = 6,
  parameter int MAX_CREDIT = MAX_CREDIT_DEFAULT
) (
  input logic posedge_clk,
  input logic rx_resetn,
  rx_credit_buffer_spw_if.slave bus
);
  localparam logic [7:0] LP_MAX = 8'(MAX_CREDIT);
  localparam logic [7:0] LP_STEP = 8'(FCT_CREDIT);
  localparam logic [8:0] LP_DEPTH = 9'(DEPTH);
  logic [5:0] r_credit;
  logic r_first_null, r_credit_error;
  logic w_empty, w_full, w_pop, w_try, w_accept, w_ack, w_fct;
  logic [8:0] w_used;
  logic [7:0] w_cred_sum;
  logic [5:0] w_cred_next;
  spw_fifo_sync #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .posedge_clk(posedge_clk),
    .rx_resetn(rx_resetn),
    .i_wr_en(w_accept),
    .i_rd_en(bus.rd_en),
    .i_wr_data(bus.rx_data_flag),
    .o_rd_data(bus.rd_data),
    .o_empty(w_empty),
    .o_full(w_full),
    .o_count(bus.fifo_count)
  );
  assign w_pop = bus.rd_en & ~w_empty;
  assign w_try = bus.rx_buffer_write & bus.link_enable & r_first_null & ~bus.rx_error;
  // A same-cycle pop frees the slot, so a full FIFO still accepts the write.
  assign w_accept = w_try & (r_credit != '0) & (~w_full | w_pop);
  assign w_used = 9'(bus.fifo_count) + 9'(r_credit) + 9'(FCT_CREDIT);
  assign w_fct = bus.link_enable & r_first_null & (w_used <= LP_DEPTH) & (8'(r_credit) + LP_STEP <= LP_MAX);
  assign w_ack = bus.fct_ack & w_fct;
  assign w_cred_sum = 8'(r_credit) + (w_ack ? LP_STEP : 8'd0) - 8'(w_accept);
  assign w_cred_next = w_cred_sum > LP_MAX ? LP_MAX[5:0] : w_cred_sum[5:0];
  assign bus.rd_valid = ~w_empty;
  assign bus.fct_request = w_fct;
  assign bus.credit_count = r_credit;
  assign bus.first_null = r_first_null;
  assign bus.credit_error = r_credit_error;
  always_ff @(posedge posedge_clk or negedge rx_resetn)
    if (!rx_resetn) begin
      r_credit <= '0;
      r_first_null <= 1'b0;
      r_credit_error <= 1'b0;
    end else if (!bus.link_enable) begin
      r_credit <= '0;
      r_first_null <= 1'b0;
      r_credit_error <= 1'b0;
    end else begin
      r_credit <= w_cred_next;
      r_first_null <= r_first_null | bus.rx_got_null;
      r_credit_error <= r_credit_error | (w_try & ~w_accept);
    end
endmodule

// File: tb/tb_rx_credit_buffer_spw.sv
// tb_rx_credit_buffer_spw: vector table, directed corner sequences and random traffic against a queue model.
module tb_rx_credit_buffer_spw;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int errors = 0;
  rx_credit_buffer_spw_if #(.AW(6)) bus();
  rx_credit_buffer_spw #(.DEPTH(64), .AW(6), .MAX_CREDIT(56)) dut (
    .posedge_clk(clk),
    .rx_resetn(rst_n),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;

  logic [8:0] mq[$];
  int m_cr;
  bit m_fn, m_err;
  logic [8:0] m_last;

  typedef struct {
    bit le, gn, er, wr, rd, ack;
    logic [8:0] d;
    int cnt, cr;
    bit req, fn, err, vld;
    logic [8:0] rdd;
  } vec_t;
  vec_t tv[11];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  function automatic bit m_req();
    return bus.link_enable && m_fn && (64 - int'(mq.size()) - m_cr >= 8) && (m_cr <= 48);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_cr = 0;
    m_fn = 0;
    m_err = 0;
    m_last = '0;
  endtask

  task automatic model_step();
    bit pop, tr, acc, rq;
    rq = m_req();
    pop = bus.rd_en && mq.size() > 0;
    tr = bus.rx_buffer_write && bus.link_enable && m_fn && !bus.rx_error;
    acc = tr && m_cr > 0 && (mq.size() < 64 || pop);
    if (pop) m_last = mq.pop_front();
    if (acc) mq.push_back(bus.rx_data_flag);
    if (!bus.link_enable) begin
      m_cr = 0;
      m_fn = 0;
      m_err = 0;
    end else begin
      m_cr = m_cr + ((bus.fct_ack && rq) ? 8 : 0) - (acc ? 1 : 0);
      if (m_cr > 56) m_cr = 56;
      m_fn = m_fn | bus.rx_got_null;
      m_err = m_err | (tr && !acc);
    end
  endtask

  task automatic check_all(input string n);
    chk({n, " count"}, 32'(bus.fifo_count), mq.size());
    chk({n, " valid"}, 32'(bus.rd_valid), 32'(mq.size() > 0));
    chk({n, " data"}, 32'(bus.rd_data), 32'(mq.size() > 0 ? mq[0] : m_last));
    chk({n, " fct_req"}, 32'(bus.fct_request), 32'(m_req()));
    chk({n, " credit"}, 32'(bus.credit_count), m_cr);
    chk({n, " first_null"}, 32'(bus.first_null), 32'(m_fn));
    chk({n, " cred_err"}, 32'(bus.credit_error), 32'(m_err));
  endtask

  task automatic drive(input bit le, gn, er, wr, rd, ack, input logic [8:0] d);
    bus.link_enable = le;
    bus.rx_got_null = gn;
    bus.rx_error = er;
    bus.rx_buffer_write = wr;
    bus.rd_en = rd;
    bus.fct_ack = ack;
    bus.rx_data_flag = d;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk_reset_vals(input string n);
    chk({n, " data"}, 32'(bus.rd_data), 0);
    chk({n, " valid"}, 32'(bus.rd_valid), 0);
    chk({n, " count"}, 32'(bus.fifo_count), 0);
    chk({n, " fct_req"}, 32'(bus.fct_request), 0);
    chk({n, " credit"}, 32'(bus.credit_count), 0);
    chk({n, " first_null"}, 32'(bus.first_null), 0);
    chk({n, " cred_err"}, 32'(bus.credit_error), 0);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, '0);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [8:0] pushed[$];
    logic [8:0] e;
    tv[0]  = '{1,0,0,0,0,0,9'h000, 0, 0,0,0,0,0,9'h000};
    tv[1]  = '{1,0,0,1,0,0,9'h033, 0, 0,0,0,0,0,9'h000};
    tv[2]  = '{1,1,0,0,0,0,9'h000, 0, 0,1,1,0,0,9'h000};
    tv[3]  = '{1,0,0,1,0,0,9'h055, 0, 0,1,1,1,0,9'h000};
    tv[4]  = '{0,0,0,0,0,0,9'h000, 0, 0,0,0,0,0,9'h000};
    tv[5]  = '{1,1,0,0,0,0,9'h000, 0, 0,1,1,0,0,9'h000};
    tv[6]  = '{1,0,0,0,0,1,9'h000, 0, 8,1,1,0,0,9'h000};
    tv[7]  = '{1,0,0,1,0,1,9'h041, 1,15,1,1,0,1,9'h041};
    tv[8]  = '{1,0,0,0,1,0,9'h000, 0,15,1,1,0,0,9'h041};
    tv[9]  = '{1,0,1,1,0,0,9'h077, 0,15,1,1,0,0,9'h041};
    tv[10] = '{1,0,0,1,0,0,9'h1aa, 1,14,1,1,0,1,9'h1aa};
    do_reset();
    for (int i = 0; i < 11; i++) begin
      drive(tv[i].le, tv[i].gn, tv[i].er, tv[i].wr, tv[i].rd, tv[i].ack, tv[i].d);
      tick();
      chk($sformatf("vec%0d count", i), 32'(bus.fifo_count), tv[i].cnt);
      chk($sformatf("vec%0d credit", i), 32'(bus.credit_count), tv[i].cr);
      chk($sformatf("vec%0d fct_req", i), 32'(bus.fct_request), 32'(tv[i].req));
      chk($sformatf("vec%0d first_null", i), 32'(bus.first_null), 32'(tv[i].fn));
      chk($sformatf("vec%0d cred_err", i), 32'(bus.credit_error), 32'(tv[i].err));
      chk($sformatf("vec%0d valid", i), 32'(bus.rd_valid), 32'(tv[i].vld));
      chk($sformatf("vec%0d data", i), 32'(bus.rd_data), 32'(tv[i].rdd));
    end

    do_reset();
    drive(1, 1, 0, 0, 0, 0, '0);
    tick();
    chk("null fct_req", 32'(bus.fct_request), 1);
    for (int i = 0; i < 7; i++) begin
      drive(1, 0, 0, 0, 0, 1, '0);
      tick();
    end
    chk("acks credit", 32'(bus.credit_count), 56);
    chk("acks fct_req", 32'(bus.fct_request), 0);
    tick();
    chk("ack ignored credit", 32'(bus.credit_count), 56);

    do_reset();
    drive(1, 1, 0, 0, 0, 0, '0);
    tick();
    drive(1, 0, 0, 0, 0, 1, '0);
    tick();
    for (int k = 0; k < 8; k++) begin
      drive(1, 0, 0, 1, 0, 0, {k == 7, 8'(8'h41 + k)});
      tick();
    end
    chk("burst count", 32'(bus.fifo_count), 8);
    chk("burst credit", 32'(bus.credit_count), 0);
    for (int k = 0; k < 8; k++) begin
      e = {k == 7, 8'(8'h41 + k)};
      chk($sformatf("burst rd%0d", k), 32'(bus.rd_data), 32'(e));
      drive(1, 0, 0, 0, 1, 0, '0);
      tick();
    end
    chk("burst drained", 32'(bus.rd_valid), 0);
    chk("burst hold data", 32'(bus.rd_data), 32'h148);

    do_reset();
    drive(1, 1, 0, 0, 0, 0, '0);
    tick();
    for (int c = 0; c < 400 && mq.size() < 64; c++) begin
      bit w;
      logic [8:0] d;
      w = m_cr > 0;
      d = 9'($urandom);
      drive(1, 0, 0, w, 0, 1, d);
      if (w) pushed.push_back(d);
      tick();
      check_all("fill");
    end
    chk("full count", 32'(bus.fifo_count), 64);
    chk("full credit", 32'(bus.credit_count), 0);
    chk("full fct_req", 32'(bus.fct_request), 0);
    drive(1, 0, 0, 1, 0, 0, 9'h055);
    tick();
    chk("full write err", 32'(bus.credit_error), 1);
    chk("full write count", 32'(bus.fifo_count), 64);
    for (int k = 0; k < 64; k++) begin
      chk($sformatf("full rd%0d", k), 32'(bus.rd_data), 32'(pushed[k]));
      drive(1, 0, 0, 0, 1, 0, '0);
      tick();
    end
    chk("full drained", 32'(bus.rd_valid), 0);

    do_reset();
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 99) < 97, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 4, $urandom_range(0, 1) == 1, 9'($urandom));
      tick();
      check_all("rand");
      if (c == 1500) begin
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
